// File: rtl/rev_pe_pkg.sv
// rtl/rev_pe_pkg.sv - shared types and constants for the reversible PE sequencer
// Purpose: FSM state enum, job status encoding and default geometry constants.
// Ports: none (package).
package rev_pe_pkg;

  localparam int DATA_NUM_DEF = 8;
  localparam int PIPE_LAT_DEF = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_RETRY = 2'd3
  } state_e;

  typedef logic [1:0] status_t;

  localparam status_t ST_OK        = 2'b00;
  localparam status_t ST_RECOVERED = 2'b01;
  localparam status_t ST_FAILED    = 2'b10;
  localparam status_t ST_ABORTED   = 2'b11;

endpackage

// File: rtl/rev_pe_vld_pipe.sv
// rtl/rev_pe_vld_pipe.sv - in-flight valid shift register and result write-address counter
// Purpose: delays each operand read by PIPE_LAT cycles into a result write strobe and
//          counts result writes to form the write address.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_push       operand read issued this cycle
//   i_flush      synchronous flush of all in-flight valids
//   i_clr        synchronous clear of the write-address counter
//   o_wr_en      result write strobe (valid leaving the pipe)
//   o_wr_addr    result write address
module rev_pe_vld_pipe
  import rev_pe_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_flush,
  input  logic              i_clr,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr
);

  logic [PIPE_LAT-1:0] r_vld;
  logic [ADDR_W-1:0]   r_wr_addr;

  // Stage i holds the valid of the read issued i+1 cycles ago, so the top
  // stage lines up with the result emerging from the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (i_flush) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_push;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr <= '0;
    end else if (i_clr) begin
      r_wr_addr <= '0;
    end else if (o_wr_en) begin
      r_wr_addr <= r_wr_addr + 1'b1;
    end
  end

  assign o_wr_en   = r_vld[PIPE_LAT-1];
  assign o_wr_addr = r_wr_addr;

endmodule

// File: rtl/rev_pe_sequencer.sv
// rtl/rev_pe_sequencer.sv - job sequencer for the reversible PE datapath
// Purpose: issues operand reads, tracks results through the pipeline, checks the
//          reverse-check error flags and reruns failed batches.
// Build option: REV_PE_SEQ_RETRY_EN enables the RETRY state and rerun logic;
//               without it a check failure ends the job as FAILED.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i, len_i    job request pulse and operand count (IDLE only)
//   abort_i           terminate current job
//   err1_i, err2_i    multiplier / adder reverse-check mismatch
//   busy_o, work_o    job in progress / datapath enable
//   rd_en_o/rd_addr_o operand buffer read port
//   wr_en_o/wr_addr_o result buffer write port
//   done_o, status_o  completion pulse and held job status
//   retry_cnt_o       reruns used by the last or current job
module rev_pe_sequencer
  import rev_pe_pkg::*;
#(
  parameter int DATA_NUM  = DATA_NUM_DEF,
  parameter int ADDR_W    = $clog2(DATA_NUM),
  parameter int PIPE_LAT  = PIPE_LAT_DEF,
  parameter int MAX_RETRY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              abort_i,
  input  logic              err1_i,
  input  logic              err2_i,
  output logic              busy_o,
  output logic              work_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              done_o,
  output logic [1:0]        status_o,
  output logic [1:0]        retry_cnt_o
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DATA_NUM);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_run_err;
  logic              r_done;
  status_t           r_status, w_status_nxt;

  logic              w_done_nxt, w_accept, w_retry, w_flush, w_rd_en, w_work;
  logic              w_err, w_last_rd, w_last_wr, w_can_retry;
  logic [1:0]        w_retry_cnt;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W:0]   w_len_m1;

  assign w_err     = err1_i | err2_i;
  assign w_len_m1  = r_len - (ADDR_W+1)'(1);
  assign w_last_rd = ({1'b0, r_rd_addr} == w_len_m1);
  assign w_last_wr = w_wr_en && ({1'b0, w_wr_addr} == w_len_m1);

`ifdef REV_PE_SEQ_RETRY_EN
  logic [1:0] r_retry_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retry_cnt <= '0;
    end else if (w_accept) begin
      r_retry_cnt <= '0;
    end else if (w_retry) begin
      r_retry_cnt <= r_retry_cnt + 1'b1;
    end
  end

  assign w_retry_cnt = r_retry_cnt;
  assign w_can_retry = (r_retry_cnt < 2'(MAX_RETRY));
`else
  logic w_unused_max_retry;

  assign w_unused_max_retry = (MAX_RETRY != 0);
  assign w_retry_cnt        = '0;
  assign w_can_retry        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    w_done_nxt   = 1'b0;
    w_accept     = 1'b0;
    w_retry      = 1'b0;
    w_flush      = 1'b0;
    w_rd_en      = 1'b0;
    w_work       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i && (len_i != '0)) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_work  = 1'b1;
        w_rd_en = 1'b1;
        if (w_last_rd) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_work = 1'b1;
        // The flags of the final result may arrive in its own write cycle.
        if (w_last_wr) begin
          if (!(r_run_err || w_err)) begin
            w_state_nxt  = S_IDLE;
            w_done_nxt   = 1'b1;
            w_status_nxt = (w_retry_cnt == 2'd0) ? ST_OK : ST_RECOVERED;
          end else if (w_can_retry) begin
            w_state_nxt = S_RETRY;
          end else begin
            w_state_nxt  = S_IDLE;
            w_done_nxt   = 1'b1;
            w_status_nxt = ST_FAILED;
          end
        end
      end
`ifdef REV_PE_SEQ_RETRY_EN
      S_RETRY: begin
        w_retry     = 1'b1;
        w_state_nxt = S_ISSUE;
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Abort overrides every transition out of a busy state.
    if (abort_i && (r_state != S_IDLE)) begin
      w_state_nxt  = S_IDLE;
      w_done_nxt   = 1'b1;
      w_status_nxt = ST_ABORTED;
      w_flush      = 1'b1;
      w_retry      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len     <= '0;
      r_rd_addr <= '0;
      r_run_err <= 1'b0;
      r_done    <= 1'b0;
      r_status  <= ST_OK;
    end else begin
      r_done   <= w_done_nxt;
      r_status <= w_status_nxt;
      if (w_accept) begin
        r_len     <= (len_i > LEN_MAX) ? LEN_MAX : len_i;
        r_rd_addr <= '0;
        r_run_err <= 1'b0;
      end else if (w_retry) begin
        r_rd_addr <= '0;
        r_run_err <= 1'b0;
      end else begin
        if (w_rd_en) begin
          r_rd_addr <= r_rd_addr + 1'b1;
        end
        if (w_work && w_err) begin
          r_run_err <= 1'b1;
        end
      end
    end
  end

  rev_pe_vld_pipe #(
    .PIPE_LAT (PIPE_LAT),
    .ADDR_W   (ADDR_W)
  ) u_vld_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_rd_en),
    .i_flush   (w_flush),
    .i_clr     (w_accept | w_retry | w_flush),
    .o_wr_en   (w_wr_en),
    .o_wr_addr (w_wr_addr)
  );

  assign busy_o      = (r_state != S_IDLE);
  assign work_o      = w_work;
  assign rd_en_o     = w_rd_en;
  assign rd_addr_o   = r_rd_addr;
  assign wr_en_o     = w_wr_en;
  assign wr_addr_o   = w_wr_addr;
  assign done_o      = r_done;
  assign status_o    = r_status;
  assign retry_cnt_o = w_retry_cnt;

endmodule

// File: tb/tb_rev_pe_sequencer.sv
// tb/tb_rev_pe_sequencer.sv - self-checking bench for rev_pe_sequencer
module tb_rev_pe_sequencer;

  localparam int DATA_NUM = 8;
  localparam int ADDR_W   = 3;
  localparam int PIPE_LAT = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W:0]   len_i = '0;
  logic              abort_i = 1'b0;
  logic              err1_i = 1'b0;
  logic              err2_i = 1'b0;
  logic              busy_o, work_o, rd_en_o, wr_en_o, done_o;
  logic [ADDR_W-1:0] rd_addr_o, wr_addr_o;
  logic [1:0]        status_o, retry_cnt_o;

  rev_pe_sequencer #(
    .DATA_NUM  (DATA_NUM),
    .ADDR_W    (ADDR_W),
    .PIPE_LAT  (PIPE_LAT),
    .MAX_RETRY (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .len_i       (len_i),
    .abort_i     (abort_i),
    .err1_i      (err1_i),
    .err2_i      (err2_i),
    .busy_o      (busy_o),
    .work_o      (work_o),
    .rd_en_o     (rd_en_o),
    .rd_addr_o   (rd_addr_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .done_o      (done_o),
    .status_o    (status_o),
    .retry_cnt_o (retry_cnt_o)
  );

  always #5 clk = ~clk;

  // err_mode: 0 none, 1 err2 pulse in cycle 3, 2 err1 held until done
  typedef struct {
    int len;
    int err_mode;
    int abort_cyc;
    int start2_cyc;
    int exp_done;
    int exp_status;
    int exp_retry;
    int exp_rd;
    int exp_wr;
  } vec_t;

  vec_t vecs[7];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start_job(input int len);
    @(negedge clk);
    start_i = 1'b1;
    len_i   = (ADDR_W+1)'(len);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Returns the cycle (counting from 1 after the start edge) where done_o is seen.
  task automatic wait_done(output int dc);
    dc = -1;
    for (int c = 1; c <= 60; c++) begin
      if (done_o) begin
        dc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   cyc, nrd, nwr, leff, addr_bad, post;
    int   done_cyc, busy_at, status_at, retry_at;
    v        = vecs[idx];
    leff     = (v.len > DATA_NUM) ? DATA_NUM : v.len;
    nrd      = 0;
    nwr      = 0;
    addr_bad = 0;
    post     = 0;
    done_cyc = -1;
    busy_at  = -1;
    status_at = -1;
    retry_at = -1;
    start_job(v.len);
    cyc = 1;
    while (cyc < 200 && post < PIPE_LAT + 3) begin
      if (rd_en_o) begin
        if (int'(rd_addr_o) != nrd % leff) addr_bad++;
        nrd++;
      end
      if (wr_en_o) begin
        if (int'(wr_addr_o) != nwr % leff) addr_bad++;
        nwr++;
      end
      if (done_o && done_cyc < 0) begin
        done_cyc  = cyc;
        busy_at   = int'(busy_o);
        status_at = int'(status_o);
        retry_at  = int'(retry_cnt_o);
      end
      if (done_cyc >= 0) post++;
      err1_i  = (v.err_mode == 2) && (done_cyc < 0);
      err2_i  = (v.err_mode == 1) && (cyc == 3);
      abort_i = (cyc == v.abort_cyc);
      start_i = (cyc == v.start2_cyc);
      if (start_i) len_i = 4'd2;
      @(negedge clk);
      cyc++;
    end
    err1_i  = 1'b0;
    err2_i  = 1'b0;
    abort_i = 1'b0;
    start_i = 1'b0;
    check($sformatf("v%0d done_cycle", idx), done_cyc, v.exp_done);
    check($sformatf("v%0d busy_at_done", idx), busy_at, 0);
    check($sformatf("v%0d status", idx), status_at, v.exp_status);
    check($sformatf("v%0d retry_cnt", idx), retry_at, v.exp_retry);
    check($sformatf("v%0d reads", idx), nrd, v.exp_rd);
    check($sformatf("v%0d writes", idx), nwr, v.exp_wr);
    check($sformatf("v%0d addr_seq_errs", idx), addr_bad, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int dc, dc2, act;

    //          len err abort st2 done st rty rd wr
    vecs[0] = '{8, 0, 0, 0, 12, 0, 0, 8, 8};
`ifdef REV_PE_SEQ_RETRY_EN
    vecs[1] = '{5, 1, 0, 0, 18, 1, 1, 10, 10};
    vecs[2] = '{3, 2, 0, 0, 21, 2, 2, 9, 9};
`else
    vecs[1] = '{5, 1, 0, 0, 9, 2, 0, 5, 5};
    vecs[2] = '{3, 2, 0, 0, 7, 2, 0, 3, 3};
`endif
    vecs[3] = '{8, 0, 5, 0, 6, 3, 0, 5, 2};
    vecs[4] = '{12, 0, 0, 0, 12, 0, 0, 8, 8};
    vecs[5] = '{1, 0, 0, 0, 5, 0, 0, 1, 1};
    vecs[6] = '{8, 0, 0, 3, 12, 0, 0, 8, 8};

    // Reset state, during and after reset
    repeat (2) @(negedge clk);
    check("reset_outputs", int'({busy_o, work_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o,
                                 done_o, status_o, retry_cnt_o}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", int'({busy_o, work_o, rd_en_o, wr_en_o, done_o,
                                      status_o, retry_cnt_o}), 0);

    for (int i = 0; i < 7; i++) begin
      run_vec(i);
    end

    // len_i = 0 and abort in IDLE: no activity at all
    @(negedge clk);
    start_i = 1'b1;
    len_i   = '0;
    abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
    act = 0;
    for (int c = 0; c < 6; c++) begin
      act += int'(busy_o) + int'(rd_en_o) + int'(wr_en_o) + int'(done_o);
      @(negedge clk);
    end
    check("len0_no_activity", act, 0);

    // start_i in the done_o cycle is accepted
    start_job(2);
    wait_done(dc);
    check("chain_first_done", dc, 6);
    start_i = 1'b1;
    len_i   = 4'd3;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(dc2);
    check("chain_second_done", dc2, 7);
    check("chain_second_status", int'(status_o), 0);

    // Reset mid-job, then a fresh job
    start_job(8);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midjob_reset_outputs", int'({busy_o, work_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o,
                                        done_o, status_o, retry_cnt_o}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_job(2);
    wait_done(dc);
    check("after_reset_done", dc, 6);
    check("after_reset_status", int'(status_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
